my_cmd_queue: RTL and testbench

Request buffer in front of the `my` slave port. It accepts read/write commands from a master through a valid/ready handshake and holds up to DEPTH of them in order. It issues them one at a time on the slave's `valid/ready/addr/data/wr_n` bus and returns read data to the master on a separate response channel. The master never stalls on slave backpressure until the queue fills.

---
 rtl/my_cmd_pkg.sv | 19 +
 rtl/my_cmd_queue_if.sv | 32 +++
 rtl/my_cmd_fifo.sv | 60 ++++++
 rtl/my_cmd_queue.sv | 95 +++++++++
 tb/tb_my_cmd_queue.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/my_cmd_pkg.sv
// Shared types for the my_cmd request queue: the queued command word and
// the issue/response FSM states.
package my_cmd_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr_n;
  } cmd_t;

  typedef enum logic {
    ISSUE,
    RSP_WAIT
  } state_t;

endpackage

// File: rtl/my_cmd_queue_if.sv
// Command bus between the queue (master) and the `my` slave port.
interface my_cmd_queue_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);

  logic              valid_o;
  logic              ready_i;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic              wr_n_o;
  logic [DATA_W-1:0] rd_data_i;

  modport master (
    output valid_o,
    output addr_o,
    output data_o,
    output wr_n_o,
    input  ready_i,
    input  rd_data_i
  );

  modport slave (
    input  valid_o,
    input  addr_o,
    input  data_o,
    input  wr_n_o,
    output ready_i,
    output rd_data_i
  );

endinterface

// File: rtl/my_cmd_fifo.sv
// In-order command store. Fullness comes from the count, never from a
// pointer compare; the head reads as zero while empty.
module my_cmd_fifo
  import my_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  cmd_t                         push_cmd,
  input  logic                         pop,
  output cmd_t                         head,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_LVL);
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head  = (count == '0) ? '0 : mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/my_cmd_queue.sv
// Request buffer in front of the `my` slave: queues master commands, issues
// them one at a time and returns read data on a separate response channel.
module my_cmd_queue #(
  parameter int unsigned ADDR_W = my_cmd_pkg::ADDR_W,
  parameter int unsigned DATA_W = my_cmd_pkg::DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  input  logic                       req_wr_n,
  my_cmd_queue_if.master             bus,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  import my_cmd_pkg::*;

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  state_t           state;
  state_t           state_nxt;
  cmd_t             push_cmd;
  cmd_t             head;
  logic             push;
  logic             pop;
  logic             issue;
  logic [LVL_W-1:0] level;

  // Registered level only, so ready_i/rsp_ready never reach req_ready.
  assign req_ready = (level < FULL_LVL);
  assign push      = req_valid && req_ready;
  assign push_cmd  = cmd_t'{addr: req_addr, data: req_data, wr_n: req_wr_n};

  my_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .level    (level)
  );

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      ISSUE: begin
        issue = (level != '0);
        if (issue && bus.ready_i && head.wr_n) begin
          state_nxt = RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        if (rsp_valid && rsp_ready) begin
          state_nxt = ISSUE;
        end
      end
    endcase
  end

  assign pop = issue && bus.ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ISSUE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state <= state_nxt;
      if (pop && head.wr_n) begin
        rsp_valid <= 1'b1;
        rsp_data  <= bus.rd_data_i;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.valid_o = issue;
  assign bus.addr_o  = head.addr;
  assign bus.data_o  = head.data;
  assign bus.wr_n_o  = head.wr_n;
  assign level_o     = level;

endmodule

// File: tb/tb_my_cmd_queue.sv
// Self-checking bench for my_cmd_queue: directed timing checks plus a
// command/response scoreboard fed from the request side.
module tb_my_cmd_queue;

  import my_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic        req_wr_n;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  level_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_issue = 0;
  int unsigned rsp_hi_cnt = 0;
  logic        rand_en = 1'b0;

  cmd_t        exp_cmd_q[$];
  logic [31:0] exp_rsp_q[$];
  cmd_t        e_cmd;
  logic [31:0] e_rsp;
  logic        stall_prev = 1'b0;
  logic [40:0] stall_cmd;
  logic        rsp_hold_prev = 1'b0;
  logic [31:0] rsp_hold_data;

  my_cmd_queue_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  my_cmd_queue #(
    .ADDR_W (8),
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_wr_n  (req_wr_n),
    .bus       (bus),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .level_o   (level_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slave_data(input logic [7:0] a);
    return (a == 8'h20) ? 32'hDEADBEEF : {24'h5A5A5A, a};
  endfunction

  assign bus.rd_data_i = slave_data(bus.addr_o);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [31:0] d, input logic w);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_wr_n  = w;
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", req_ready, 1);
    check("rst_valid", bus.valid_o, 0);
    check("rst_addr", bus.addr_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_wr_n", bus.wr_n_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_level", level_o, 0);
  endtask

  task automatic wait_accept();
    int unsigned k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("accept_in_time", req_ready, 1);
    step();
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    bus.ready_i = 1'b1;
    rsp_ready   = 1'b1;
    @(negedge clk);
    while (!(level_o == 0 && !rsp_valid && exp_cmd_q.size() == 0 && exp_rsp_q.size() == 0)
           && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drained", {level_o, rsp_valid}, 0);
    step();
    bus.ready_i = 1'b0;
    rsp_ready   = 1'b0;
  endtask

  // Scoreboard and stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_cmd_q.delete();
      exp_rsp_q.delete();
      stall_prev    = 1'b0;
      rsp_hold_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", bus.valid_o, 1);
        check("hold_cmd", {bus.addr_o, bus.data_o, bus.wr_n_o}, stall_cmd);
      end
      if (rsp_hold_prev) begin
        check("rsp_hold_valid", rsp_valid, 1);
        check("rsp_hold_data", rsp_data, rsp_hold_data);
      end
      if (bus.valid_o && bus.ready_i) begin
        n_issue++;
        if (exp_cmd_q.size() == 0) begin
          check("issue_unexpected", bus.valid_o, 0);
        end else begin
          e_cmd = exp_cmd_q.pop_front();
          check("issue_cmd", {bus.addr_o, bus.data_o, bus.wr_n_o}, e_cmd);
          if (e_cmd.wr_n) exp_rsp_q.push_back(slave_data(e_cmd.addr));
        end
      end
      if (rsp_valid) rsp_hi_cnt++;
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          e_rsp = exp_rsp_q.pop_front();
          check("rsp_data", rsp_data, e_rsp);
        end
      end
      if (req_valid && req_ready) begin
        exp_cmd_q.push_back(cmd_t'{addr: req_addr, data: req_data, wr_n: req_wr_n});
      end
      stall_prev    = bus.valid_o && !bus.ready_i;
      stall_cmd     = {bus.addr_o, bus.data_o, bus.wr_n_o};
      rsp_hold_prev = rsp_valid && !rsp_ready;
      rsp_hold_data = rsp_data;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_en) begin
      bus.ready_i = 1'($urandom_range(0, 1));
      rsp_ready   = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_data    = '0;
    req_wr_n    = 1'b0;
    rsp_ready   = 1'b0;
    bus.ready_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    step();

    // Write burst with the slave always ready.
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'h10 + 8'(i), 32'hA0 + 32'(i), 1'b0);
      @(negedge clk);
      if (i == 0) check("t1_no_passthru", bus.valid_o, 0);
      else        check("t1_back_to_back", bus.valid_o, 1);
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("t1_last_issue", {bus.valid_o, bus.addr_o}, {1'b1, 8'h13});
    step();
    @(negedge clk);
    check("t1_empty_valid", bus.valid_o, 0);
    check("t1_no_rsp", rsp_hi_cnt, 0);
    step();

    // Fill against a stalled slave, then release it.
    bus.ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'h30 + 8'(i), 32'hB0 + 32'(i), 1'b0);
      @(negedge clk);
      check("t2_ready", req_ready, 1);
      step();
    end
    drive(8'h34, 32'hB4, 1'b0);
    @(negedge clk);
    check("t2_full_ready", req_ready, 0);
    check("t2_full_level", level_o, 4);
    check("t2_head", {bus.valid_o, bus.addr_o}, {1'b1, 8'h30});
    step();
    step();
    @(negedge clk);
    check("t2_not_taken", level_o, 4);
    step();
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("t2_no_bypass", req_ready, 0);
    step();
    @(negedge clk);
    check("t2_ready_back", req_ready, 1);
    check("t2_level3", level_o, 3);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("t2_pushpop_level", level_o, 3);
    wait_idle();

    // Read round-trip with the response held.
    bus.ready_i = 1'b1;
    rsp_ready   = 1'b0;
    drive(8'h20, 32'h0, 1'b1);
    @(negedge clk);
    check("t3_no_passthru", bus.valid_o, 0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("t3_issue", {bus.valid_o, bus.wr_n_o, bus.addr_o}, {2'b11, 8'h20});
    step();
    @(negedge clk);
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_rsp_data", rsp_data, 32'hDEADBEEF);
    check("t3_no_issue", bus.valid_o, 0);
    step();
    step();
    @(negedge clk);
    check("t3_rsp_held", rsp_valid, 1);
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("t3_rsp_cleared", rsp_valid, 0);
    step();

    // Read then write; the write waits for the response handshake.
    bus.ready_i = 1'b1;
    drive(8'h21, 32'h0, 1'b1);
    step();
    drive(8'h40, 32'hC0, 1'b0);
    @(negedge clk);
    check("t4_read_issue", {bus.valid_o, bus.wr_n_o}, 2'b11);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_blocked", {bus.valid_o, rsp_valid}, 2'b01);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_blocked_hs", bus.valid_o, 0);
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("t4_write_issue", {bus.valid_o, bus.addr_o, bus.wr_n_o}, {1'b1, 8'h40, 1'b0});
    wait_idle();

    // Interleaved traffic across pointer wrap, random backpressure.
    rand_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(8'h50 + 8'(i), 32'hD0 + 32'(i), (i % 3) == 1);
      wait_accept();
    end
    req_valid = 1'b0;
    wait_idle();
    rand_en = 1'b0;
    step();
    bus.ready_i = 1'b0;
    rsp_ready   = 1'b0;

    // Reset with entries queued and a response pending.
    bus.ready_i = 1'b1;
    drive(8'h22, 32'h0, 1'b1);
    step();
    req_valid = 1'b0;
    step();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(8'h71 + 8'(i), 32'hE1 + 32'(i), 1'b0);
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("t6_pre_level", level_o, 3);
    check("t6_pre_rsp", rsp_valid, 1);
    step();
    reset = 1'b1;
    drive(8'h99, 32'h99, 1'b0);
    step();
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check_reset_vals();
    step();
    bus.ready_i = 1'b1;
    drive(8'h74, 32'hE4, 1'b0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("t6_post_issue", {bus.valid_o, bus.addr_o, bus.data_o}, {1'b1, 8'h74, 32'hE4});
    wait_idle();

    check("sb_cmd_left", exp_cmd_q.size(), 0);
    check("sb_rsp_left", exp_rsp_q.size(), 0);
    check("issue_total", n_issue, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
